// File: rtl/pulse_sched_pkg.sv
// Shared constants for the pulse transfer scheduler: FSM encoding, width helpers,
// and default spacing/timeout values.
package pulse_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int DEF_HOLDOFF = 16;
  localparam int DEF_TIMEOUT = 64;

  // A single requester still needs a one-bit index so the ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int holdoff, input int timeout);
    int m;
    m = (holdoff > timeout) ? holdoff : timeout;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of pending at or after ptr+1,
// wrapping modulo N_REQ.
module rr_picker
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    j     = 0;
    idx   = '0;
    valid = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      j = (int'(ptr) + off) % N_REQ;
      if (!valid && pending[j]) begin
        valid = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/pulse_xfer_scheduler.sv
// Round-robin scheduler sharing one toggle-synchronizer pulse channel among N_REQ
// requesters. Define PULSE_SCHED_ACK_EN to pace on ack_in (with timeout) instead of HOLDOFF.
module pulse_xfer_scheduler
  import pulse_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int HOLDOFF = DEF_HOLDOFF,
  parameter int TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W = idx_width(N_REQ),
  localparam int CNT_W = cnt_width(HOLDOFF, TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic             ack_in,
  input  logic             sticky_clr,
  output logic             pulse_out,
  output logic [IDX_W-1:0] grant_id,
  output logic             busy,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] ovf,
  output logic             timeout_err
);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             grant;
  logic [N_REQ-1:0] grant_mask;
  logic             hold_exit;
  logic [CNT_W-1:0] cnt_load;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .pending (pending),
    .ptr     (ptr),
    .idx     (pick_idx),
    .valid   (pick_valid)
  );

  assign grant      = (state == ST_IDLE) && pick_valid;
  assign grant_mask = grant ? (N_REQ'(1) << pick_idx) : '0;

`ifdef PULSE_SCHED_ACK_EN
  logic timeout_hit;
  assign cnt_load    = CNT_W'(TIMEOUT - 1);
  assign hold_exit   = ack_in || (cnt == '0);
  assign timeout_hit = !ack_in && (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_err <= 1'b0;
    end else if (sticky_clr) begin
      timeout_err <= 1'b0;
    end else if (state == ST_HOLD && timeout_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_ack;
  assign unused_ack  = ack_in;
  assign cnt_load    = CNT_W'(HOLDOFF - 1);
  assign hold_exit   = (cnt == '0);
  assign timeout_err = 1'b0;
`endif

  // A request landing on the edge its own grant clears it re-arms pending without overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= '0;
      ovf     <= '0;
    end else begin
      pending <= (pending & ~grant_mask) | req_in;
      if (sticky_clr) begin
        ovf <= '0;
      end else begin
        ovf <= ovf | (req_in & pending & ~grant_mask);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      ptr       <= '0;
      grant_id  <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      pulse_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            grant_id <= pick_idx;
            ptr      <= pick_idx;
            state    <= ST_ISSUE;
            busy     <= 1'b1;
          end
        end
        ST_ISSUE: begin
          pulse_out <= 1'b1;
          cnt       <= cnt_load;
          state     <= ST_HOLD;
          busy      <= 1'b1;
        end
        ST_HOLD: begin
          if (hold_exit) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_xfer_scheduler.sv
// Directed self-checking bench for pulse_xfer_scheduler (N_REQ=4, HOLDOFF=16, TIMEOUT=64).
// Define PULSE_SCHED_ACK_EN to exercise the ack/timeout pacing instead of fixed HOLDOFF.
module tb_pulse_xfer_scheduler;

  logic       clk;
  logic       rst;
  logic [3:0] req_in;
  logic       ack_in;
  logic       sticky_clr;
  logic       pulse_out;
  logic [1:0] grant_id;
  logic       busy;
  logic [3:0] pending;
  logic [3:0] ovf;
  logic       timeout_err;

  int n_checks;
  int n_fail;
  int cyc;
  int busy_cnt;
  int req_cyc;
  int pulse_ids[$];
  int pulse_cyc[$];

  pulse_xfer_scheduler #(.N_REQ(4), .HOLDOFF(16), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .ack_in      (ack_in),
    .sticky_clr  (sticky_clr),
    .pulse_out   (pulse_out),
    .grant_id    (grant_id),
    .busy        (busy),
    .pending     (pending),
    .ovf         (ovf),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      if (pulse_out) begin
        pulse_ids.push_back(int'(grant_id));
        pulse_cyc.push_back(cyc);
      end
      if (busy) busy_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic clr, input logic ack);
    @(negedge clk);
    req_in     = r;
    sticky_clr = clr;
    ack_in     = ack;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    pulse_ids.delete();
    pulse_cyc.delete();
    busy_cnt = 0;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    busy_cnt   = 0;
    req_in     = '0;
    ack_in     = 1'b0;
    sticky_clr = 1'b0;
    rst        = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {pulse_out, grant_id, busy, pending, ovf, timeout_err}, 32'h0);
    rst = 1'b1;
    idle_cycles(2);

`ifndef PULSE_SCHED_ACK_EN
    // Single request: one pulse, id 0, two cycles after the sampling edge, 17 busy cycles
    clear_log();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    req_cyc = cyc + 1;
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t1_pending_set", pending, 4'b0001);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t1_grant_id", grant_id, 0);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_pending_clr", pending, 0);
    idle_cycles(25);
    checkOutput("t1_pulse_count", pulse_ids.size(), 1);
    if (pulse_ids.size() == 1) begin
      checkOutput("t1_pulse_id", pulse_ids[0], 0);
      checkOutput("t1_latency", pulse_cyc[0], req_cyc + 2);
    end
    checkOutput("t1_busy_cycles", busy_cnt, 17);

    // All four at once: served 1,2,3,0 at 18-cycle spacing
    clear_log();
    applyStimulus(4'b1111, 1'b0, 1'b0);
    req_cyc = cyc + 1;
    idle_cycles(80);
    checkOutput("t2_pulse_count", pulse_ids.size(), 4);
    if (pulse_ids.size() == 4) begin
      checkOutput("t2_latency", pulse_cyc[0], req_cyc + 2);
      checkOutput("t2_id0", pulse_ids[0], 1);
      checkOutput("t2_id1", pulse_ids[1], 2);
      checkOutput("t2_id2", pulse_ids[2], 3);
      checkOutput("t2_id3", pulse_ids[3], 0);
      for (int i = 1; i < 4; i++)
        checkOutput($sformatf("t2_spacing%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 18);
    end
    checkOutput("t2_pending_drained", pending, 0);
    checkOutput("t2_busy_end", busy, 0);

    // Overflow on repeated req[2] while pending, then sticky clear (also vs simultaneous set)
    clear_log();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_ovf_set", ovf, 4'b0100);
    checkOutput("t3_pending_held", pending, 4'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_ovf_cleared", ovf, 0);
    checkOutput("t3_pending_after_clr", pending, 4'b0100);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t3_clr_wins", ovf, 0);
    idle_cycles(45);
    checkOutput("t3_pulse_count", pulse_ids.size(), 2);
    if (pulse_ids.size() == 2) checkOutput("t3_second_id", pulse_ids[1], 2);
    checkOutput("t3_pending_drained", pending, 0);

    // Request on the same edge as its own grant: re-arms without overflow
    clear_log();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t4_grant_id", grant_id, 1);
    checkOutput("t4_pending_rearmed", pending, 4'b0010);
    checkOutput("t4_no_ovf", ovf, 0);
    idle_cycles(45);
    checkOutput("t4_pulse_count", pulse_ids.size(), 2);
    if (pulse_ids.size() == 2) begin
      checkOutput("t4_id_second", pulse_ids[1], 1);
      checkOutput("t4_spacing", pulse_cyc[1] - pulse_cyc[0], 18);
    end

    // Asynchronous reset during HOLD with requests pending
    applyStimulus(4'b0100, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b1010, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t5_grant_before", grant_id, 2);
    checkOutput("t5_busy_before", busy, 1);
    checkOutput("t5_pending_before", pending, 4'b1010);
    #2 rst = 1'b0;
    #1;
    checkOutput("t5_reset_outputs", {pulse_out, grant_id, busy, pending, ovf, timeout_err}, 32'h0);
    repeat (2) @(negedge clk);
    clear_log();
    rst = 1'b1;
    idle_cycles(30);
    checkOutput("t5_no_pulse", pulse_ids.size(), 0);
    checkOutput("t5_pending_empty", pending, 0);
    checkOutput("t5_busy_idle", busy, 0);
`else
    // Ack five cycles after the pulse ends HOLD on the sampling edge
    clear_log();
    applyStimulus(4'b0001, 1'b0, 1'b0);
    idle_cycles(3);
    checkOutput("t6_pulse", pulse_out, 1);
    checkOutput("t6_grant_id", grant_id, 0);
    idle_cycles(4);
    applyStimulus(4'b0000, 1'b0, 1'b1);
    checkOutput("t6_busy_before_ack", busy, 1);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t6_idle_after_ack", busy, 0);
    checkOutput("t6_no_timeout", timeout_err, 0);
    idle_cycles(5);

    // No ack: 64 HOLD cycles plus ISSUE, then sticky timeout
    clear_log();
    applyStimulus(4'b0010, 1'b0, 1'b0);
    idle_cycles(80);
    checkOutput("t6_busy_cycles", busy_cnt, 65);
    checkOutput("t6_timeout_set", timeout_err, 1);
    checkOutput("t6_pulse_count", pulse_ids.size(), 1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0);
    checkOutput("t6_timeout_cleared", timeout_err, 0);
    checkOutput("t6_pending_empty", pending, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
